// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the chunk-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal geometry: 1 <= chunk <= width and width divisible by chunk.
  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational CHUNK-bit ripple-borrow subtractor: d = x - y - bi.
module sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo = br[CHUNK];

endmodule

// File: rtl/serial_chunk_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle with a
// registered borrow between slices and a start/busy/done handshake.
module serial_chunk_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("serial_chunk_sub: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] opa, opb, dsr, dsr_nxt;
  logic             borrow, a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] sd;
  logic             sbo;

  sub_slice #(.CHUNK(CHUNK)) u_slice (
    .x  (opa[CHUNK-1:0]),
    .y  (opb[CHUNK-1:0]),
    .bi (borrow),
    .d  (sd),
    .bo (sbo)
  );

  // New slice result enters at the top; after NCHUNK shifts the first chunk sits lowest.
  assign dsr_nxt = (dsr >> CHUNK) | (WIDTH'(sd) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      dsr    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa    <= a;
            opb    <= b;
            borrow <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          opa    <= opa >> CHUNK;
          opb    <= opb >> CHUNK;
          borrow <= sbo;
          dsr    <= dsr_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= dsr_nxt;
            bout  <= sbo;
            ovf   <= (a_msb ^ b_msb) & (dsr_nxt[WIDTH-1] ^ a_msb);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_chunk_sub.md
Name: serial_chunk_sub

Overview:
Multi-cycle, parametrised two's-complement subtractor computing diff = a - b - bin over WIDTH bits. It processes CHUNK bits per cycle through a ripple-borrow slice and propagates the borrow between slices in a register. It replaces single-bit half/full subtractor cells wherever wide operands must be subtracted with low area. A start/busy/done handshake makes it usable inside datapath controllers.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a subtraction; sampled only in IDLE or DONE.
a  input  WIDTH  minuend; sampled on the accepted start.
b  input  WIDTH  subtrahend; sampled on the accepted start.
bin  input  1  borrow-in to bit 0; sampled on the accepted start.
busy  output  1  high while an operation is in RUN.
done  output  1  one-cycle pulse; results valid.
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
bout  output  1  borrow-out of the MSB (unsigned a < b + bin).
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; busy, done, diff, bout, ovf all 0; internal shift registers, borrow register and chunk counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a, b, bin into operand shift regs and the borrow reg; counter=0; go RUN. start=0 -> stay.
- RUN: busy=1. Each cycle, the slice computes the low CHUNK bits of opA - opB - borrow. Shift the result into the top of the diff shift reg (LSB chunk enters first and ends lowest). Shift opA/opB right by CHUNK. Update the borrow reg with the slice borrow-out. counter++. After NCHUNK RUN cycles go DONE.
- DONE: busy=0, done=1 for exactly this cycle. diff/bout/ovf are updated on entry to DONE. They hold until the next accepted start. Go IDLE, or go RUN directly if start=1 in DONE (back-to-back accepted identically to IDLE).
- Latency: start accepted at edge T -> done high in the cycle after edge T+NCHUNK, i.e. NCHUNK+1 cycles start-to-done. Throughput: one operation per NCHUNK+1 cycles.
- start while in RUN is ignored; no queuing. Inputs a/b/bin may change freely after the accepting edge.
- ovf uses the latched MSBs of a and b, held in dedicated flops.
- CHUNK==WIDTH: NCHUNK=1; one RUN cycle; still 2-cycle latency.
- Wrap-around: result is modulo 2^WIDTH; bout flags an unsigned underflow.
- rst mid-RUN aborts: outputs return to 0 immediately and no done is issued. The first start after deassert is accepted normally.
- Counter width: $clog2(NCHUNK+1); it must not wrap inside RUN.

Decomposition:
- Shared package sub_pkg: FSM state enum (IDLE, RUN, DONE) and a WIDTH % CHUNK == 0 elaboration check (assertion/function).
- One sub-module: sub_slice, a combinational CHUNK-bit ripple-borrow subtractor (x, y, bi -> d, bo) built from full-subtractor equations d = x^y^bi, bo = (~x&y) | (~(x^y)&bi).

Test Plan:
1. WIDTH=16, CHUNK=4: a=0x1234, b=0x0234, bin=0, start pulse -> busy high 4 cycles; done pulse 5 cycles after start; diff=0x1000, bout=0, ovf=0.
2. Underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Also a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
3. Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
4. Handshake: start re-asserted during RUN with different a/b -> ignored, first result unchanged. start held high through DONE -> second op begins with no IDLE cycle, done pulses spaced 5 cycles apart.
5. rst asserted in the 2nd RUN cycle -> busy/done/diff/bout/ovf = 0 asynchronously, no done. After deassert, a=0x00FF, b=0x000F -> diff=0x00F0.
6. Parameter sweep CHUNK in {1, 4, 16} with WIDTH=16, 1000 random a/b/bin -> diff/bout/ovf match the reference model {bout,diff} = a - b - bin (17-bit). Latency = NCHUNK+1 for every run.
